hazard_stall_ctrl: RTL

//  Pipeline sequencing controller for the 5-stage integer/FP datapath.

---
 rtl/hazard_stall_ctrl_if.sv | 33 +++
 rtl/hazard_stall_ctrl.sv | 146 ++++++++++++++
 2 files changed

// File: rtl/hazard_stall_ctrl_if.sv
// Decode-side hazard bus between the ID stage and the pipeline sequencing controller.
// Carries the ID instruction, EX load and redirect status toward the controller,
//   and the stall/bubble/flush/multiply controls plus the stall counter back.
// master: pipeline side that drives ID/EX status and consumes controls.
// slave : the controller that consumes ID/EX status and drives controls.
// Instruction and register fields are numbered MSB-first (bit 0 = opcode MSB).
interface hazard_stall_ctrl_if #(
  parameter int CNT_W = 16
);
  logic [0:31]      id_instr;
  logic             id_valid;
  logic             ex_mem2reg;
  logic [0:4]       ex_rd;
  logic             redirect;

  logic             pc_stall;
  logic             ifid_stall;
  logic             idex_bubble;
  logic             ifid_flush;
  logic             mul_go;
  logic             mul_busy;
  logic [CNT_W-1:0] stall_cnt;

  modport master (
    output id_instr, id_valid, ex_mem2reg, ex_rd, redirect,
    input  pc_stall, ifid_stall, idex_bubble, ifid_flush, mul_go, mul_busy, stall_cnt
  );

  modport slave (
    input  id_instr, id_valid, ex_mem2reg, ex_rd, redirect,
    output pc_stall, ifid_stall, idex_bubble, ifid_flush, mul_go, mul_busy, stall_cnt
  );
endinterface

// File: rtl/hazard_stall_ctrl.sv
// Pipeline sequencing controller: stall/bubble/flush for load-use, redirects, multi-cycle multiply.
// Latency: controls are combinational in the same cycle; mul_busy and stall_cnt are registered.
// Backpressure: pc_stall/ifid_stall hold the front end; MUL state holds it MUL_LATENCY-1 cycles.
// Ports:
//   clk, reset  : clock and synchronous active-high reset
//   bus (slave) : ID instruction/valid, EX load flag and rd, redirect in;
//                 pc_stall, ifid_stall, idex_bubble, ifid_flush, mul_go, mul_busy, stall_cnt out
module hazard_stall_ctrl #(
  parameter int MUL_LATENCY = 4,
  parameter int CNT_W       = 16
) (
  input  logic                clk,
  input  logic                reset,
  hazard_stall_ctrl_if.slave  bus
);

  // Remaining-cycle counter holds at most MUL_LATENCY-2.
  localparam int CW   = (MUL_LATENCY > 2) ? $clog2(MUL_LATENCY - 1) : 1;
  localparam int LOAD = (MUL_LATENCY > 1) ? (MUL_LATENCY - 2) : 0;

  typedef enum logic {
    RUN = 1'b0,
    MUL = 1'b1
  } state_t;

  state_t           state;
  state_t           state_nxt;
  logic [CW-1:0]    count;
  logic [CW-1:0]    count_nxt;
  logic             busy;
  logic [CNT_W-1:0] stall_count;

  // ---------------- decode ----------------
  logic [0:5] op;
  logic [0:4] rs1;
  logic [0:4] rs2;
  logic [0:5] funct;
  logic       uses_rs1;
  logic       uses_rs2;
  logic       is_mult;
  logic       load_use;
  logic       unused_fields;

  assign op    = bus.id_instr[0:5];
  assign rs1   = bus.id_instr[6:10];
  assign rs2   = bus.id_instr[11:15];
  assign funct = bus.id_instr[26:31];

  // rd/shamt bits never take part in hazard detection.
  assign unused_fields = ^bus.id_instr[16:25];

  // Jumps (00001x) carry a target in the rs1 field, not a register.
  assign uses_rs1 = (op[0:4] != 5'b00001);
  // Stores (101xxx) read their data register through rs2.
  assign uses_rs2 = (op == 6'b000000) || (op == 6'b000001) || (op[0:2] == 3'b101);
  // Two funct codes in the 000001 group are single-cycle and must not start the multiplier.
  assign is_mult  = (op == 6'b000001) && (funct != 6'b110100) && (funct != 6'b110101);

  // r0 is hardwired zero, so a load targeting it never creates a dependency.
  assign load_use = bus.id_valid && bus.ex_mem2reg && (bus.ex_rd != 5'd0) &&
                    ((uses_rs1 && (rs1 == bus.ex_rd)) || (uses_rs2 && (rs2 == bus.ex_rd)));

  // ---------------- next state / outputs ----------------
  logic pc_stall;
  logic ifid_stall;
  logic idex_bubble;
  logic ifid_flush;
  logic mul_go;

  always_comb begin
    state_nxt   = state;
    count_nxt   = count;
    pc_stall    = 1'b0;
    ifid_stall  = 1'b0;
    idex_bubble = 1'b0;
    ifid_flush  = 1'b0;
    mul_go      = 1'b0;

    if (!reset) begin
      unique case (state)
        RUN: begin
          if (bus.redirect) begin
            // The ID instruction is on the wrong path: drop it, let fetch continue at the target.
            ifid_flush  = 1'b1;
            idex_bubble = 1'b1;
          end else if (load_use) begin
            // One bubble is enough: next cycle the load is in MEM and forwarding covers it.
            pc_stall    = 1'b1;
            ifid_stall  = 1'b1;
            idex_bubble = 1'b1;
          end else if (bus.id_valid && is_mult) begin
            // The multiply itself enters EX now; the stall covers the instructions behind it.
            mul_go = 1'b1;
            if (MUL_LATENCY > 1) begin
              state_nxt = MUL;
              count_nxt = CW'(LOAD);
            end
          end
        end

        MUL: begin
          // EX is occupied by the multiply, so no branch can resolve here; redirect is ignored.
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_bubble = 1'b1;
          if (count == '0) begin
            state_nxt = RUN;
          end else begin
            count_nxt = count - 1'b1;
          end
        end

        default: begin
          state_nxt = RUN;
        end
      endcase
    end
  end

  // ---------------- state ----------------
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= RUN;
      count       <= '0;
      busy        <= 1'b0;
      stall_count <= '0;
    end else begin
      state <= state_nxt;
      count <= count_nxt;
      busy  <= (state_nxt == MUL);
      // Saturate instead of wrapping so long runs still read as "at least max".
      if (pc_stall && (stall_count != {CNT_W{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

  assign bus.pc_stall    = pc_stall;
  assign bus.ifid_stall  = ifid_stall;
  assign bus.idex_bubble = idex_bubble;
  assign bus.ifid_flush  = ifid_flush;
  assign bus.mul_go      = mul_go;
  assign bus.mul_busy    = busy;
  assign bus.stall_cnt   = stall_count;

endmodule
